ysyx_23060203_rd_xbar: RTL and testbench

Read-channel AXI4 router between the core's load/fetch master and its two read targets: the CLINT timer at `CLINT_BASE` and the SoC bus for all other addresses. It accepts one outstanding read and decodes `araddr` in the AR phase. CLINT reads are served from a latched request; SoC reads are forwarded verbatim. Write channels do not pass through this block.

---
 rtl/ysyx_23060203_rd_xbar_if.sv | 33 +++
 rtl/ysyx_23060203_rd_xbar.sv | 163 ++++++++++++++++
 tb/tb_ysyx_23060203_rd_xbar.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060203_rd_xbar_if.sv
`default_nettype none
// ============================================================================
// axi_if : AXI4 read-channel bundle (AR + R) shared by the read crossbar ports
// Revision: 1.0
// ============================================================================
interface axi_if;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
    logic        rvalid;
    logic        rready;

    // Subordinate side: receives AR, returns R
    modport in (
        input  araddr, arid, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rid, rvalid
    );

    // Manager side: issues AR, accepts R
    modport out (
        output araddr, arid, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rid, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_23060203_rd_xbar.sv
`default_nettype none
// ============================================================================
// ysyx_23060203_rd_xbar : one-outstanding AXI4 read router, CLINT window vs SoC
// Revision: 1.0
// ============================================================================
module ysyx_23060203_rd_xbar #(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000
) (
    input  logic  clock,
    input  logic  reset,
    axi_if.in     up,
    axi_if.out    clint,
    axi_if.out    soc
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SOC_AR  = 3'd1,
        SOC_R   = 3'd2,
        CLINT_R = 3'd3,
        ERR_R   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  id_q, id_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;

    logic hit;
    assign hit = (up.araddr & CLINT_MASK) == CLINT_BASE;

    // CLINT always answers with a single OKAY beat; its R handshake flags are not needed
    logic unused_clint;
    assign unused_clint = &{1'b0, clint.arready, clint.rvalid, clint.rlast, clint.rid};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            id_q    <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        id_d    = id_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;

        up.arready = 1'b0;
        up.rvalid  = 1'b0;
        up.rdata   = '0;
        up.rresp   = '0;
        up.rlast   = 1'b0;
        up.rid     = '0;

        soc.araddr  = addr_q;
        soc.arid    = id_q;
        soc.arlen   = len_q;
        soc.arsize  = size_q;
        soc.arburst = burst_q;
        soc.arvalid = 1'b0;
        soc.rready  = 1'b0;

        // Latched address keeps CLINT rdata stable while a beat is stalled
        clint.araddr  = addr_q;
        clint.arid    = id_q;
        clint.arlen   = 8'd0;
        clint.arsize  = 3'd2;
        clint.arburst = 2'b01;
        clint.arvalid = 1'b0;
        clint.rready  = 1'b0;

        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (up.arvalid) begin
                        if (hit) begin
                            up.arready = 1'b1;
                            id_d       = up.arid;
                            if (up.arlen == 8'd0) begin
                                addr_d  = up.araddr;
                                state_d = CLINT_R;
                            end else begin
                                state_d = ERR_R;
                            end
                        end else begin
                            soc.araddr  = up.araddr;
                            soc.arid    = up.arid;
                            soc.arlen   = up.arlen;
                            soc.arsize  = up.arsize;
                            soc.arburst = up.arburst;
                            soc.arvalid = 1'b1;
                            up.arready  = soc.arready;
                            addr_d      = up.araddr;
                            id_d        = up.arid;
                            len_d       = up.arlen;
                            size_d      = up.arsize;
                            burst_d     = up.arburst;
                            state_d     = soc.arready ? SOC_R : SOC_AR;
                        end
                    end
                end
                SOC_AR: begin
                    soc.arvalid = 1'b1;
                    if (soc.arready) begin
                        state_d = SOC_R;
                    end
                end
                SOC_R: begin
                    up.rvalid  = soc.rvalid;
                    up.rdata   = soc.rdata;
                    up.rresp   = soc.rresp;
                    up.rlast   = soc.rlast;
                    up.rid     = soc.rid;
                    soc.rready = up.rready;
                    if (soc.rvalid && up.rready && soc.rlast) begin
                        state_d = IDLE;
                    end
                end
                CLINT_R: begin
                    clint.arvalid = 1'b1;
                    clint.rready  = up.rready;
                    up.rvalid     = 1'b1;
                    up.rdata      = clint.rdata;
                    up.rresp      = clint.rresp;
                    up.rlast      = 1'b1;
                    up.rid        = id_q;
                    if (up.rready) begin
                        state_d = IDLE;
                    end
                end
                ERR_R: begin
                    up.rvalid = 1'b1;
                    up.rresp  = 2'b10;
                    up.rlast  = 1'b1;
                    up.rid    = id_q;
                    if (up.rready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060203_rd_xbar.sv
`default_nettype none
// ============================================================================
// tb_ysyx_23060203_rd_xbar : directed table + corner sequences for the read router
// Revision: 1.0
// ============================================================================
module tb_ysyx_23060203_rd_xbar;

    localparam int K_CLINT = 0;
    localparam int K_ERR   = 1;
    localparam int K_SOC   = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Free-running timer behind the CLINT stub; starts near a low-word carry
    logic [63:0] cnt = 64'h0000_0001_FFFF_FFF8;
    always @(posedge clock) cnt <= cnt + 64'd1;

    axi_if up_if();
    axi_if clint_if();
    axi_if soc_if();

    assign clint_if.arready = 1'b1;
    assign clint_if.rvalid  = 1'b1;
    assign clint_if.rresp   = 2'b00;
    assign clint_if.rlast   = 1'b1;
    assign clint_if.rid     = 4'h0;
    assign clint_if.rdata   = clint_if.araddr[2] ? cnt[63:32] : cnt[31:0];

    ysyx_23060203_rd_xbar dut (
        .clock (clock),
        .reset (reset),
        .up    (up_if),
        .clint (clint_if),
        .soc   (soc_if)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        int          kind;
        logic [31:0] sdata;
        logic [1:0]  sresp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] clint_word(input logic [31:0] a);
        return a[2] ? cnt[63:32] : cnt[31:0];
    endfunction

    task automatic idle_inputs();
        up_if.araddr   = '0;
        up_if.arid     = '0;
        up_if.arlen    = '0;
        up_if.arsize   = 3'd2;
        up_if.arburst  = 2'b01;
        up_if.arvalid  = 1'b0;
        up_if.rready   = 1'b1;
        soc_if.arready = 1'b0;
        soc_if.rvalid  = 1'b0;
        soc_if.rdata   = '0;
        soc_if.rresp   = '0;
        soc_if.rlast   = 1'b0;
        soc_if.rid     = '0;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        @(posedge clock); #1;
        up_if.araddr   = v.addr;
        up_if.arid     = v.id;
        up_if.arlen    = v.len;
        up_if.arvalid  = 1'b1;
        up_if.rready   = 1'b1;
        soc_if.arready = (v.kind == K_SOC);
        @(negedge clock);
        chk($sformatf("v%0d_arready", n), 64'(up_if.arready), 64'(1));
        chk($sformatf("v%0d_soc_arvalid", n), 64'(soc_if.arvalid), 64'(v.kind == K_SOC));
        if (v.kind == K_SOC)
            chk($sformatf("v%0d_soc_araddr", n), 64'(soc_if.araddr), 64'(v.addr));
        @(posedge clock); #1;
        up_if.arvalid  = 1'b0;
        soc_if.arready = 1'b0;
        if (v.kind == K_SOC) begin
            soc_if.rvalid = 1'b1;
            soc_if.rdata  = v.sdata;
            soc_if.rresp  = v.sresp;
            soc_if.rlast  = 1'b1;
            soc_if.rid    = v.id;
        end
        @(negedge clock);
        exp_data = (v.kind == K_CLINT) ? clint_word(v.addr) : (v.kind == K_ERR) ? 32'h0 : v.sdata;
        exp_resp = (v.kind == K_ERR) ? 2'b10 : (v.kind == K_SOC) ? v.sresp : 2'b00;
        chk($sformatf("v%0d_rvalid", n), 64'(up_if.rvalid), 64'(1));
        chk($sformatf("v%0d_rdata", n), 64'(up_if.rdata), 64'(exp_data));
        chk($sformatf("v%0d_rresp", n), 64'(up_if.rresp), 64'(exp_resp));
        chk($sformatf("v%0d_rlast", n), 64'(up_if.rlast), 64'(1));
        chk($sformatf("v%0d_rid", n), 64'(up_if.rid), 64'(v.id));
        chk($sformatf("v%0d_clint_arvalid", n), 64'(clint_if.arvalid), 64'(v.kind == K_CLINT));
        @(posedge clock); #1;
        soc_if.rvalid = 1'b0;
        soc_if.rlast  = 1'b0;
        @(negedge clock);
        chk($sformatf("v%0d_rvalid_done", n), 64'(up_if.rvalid), 64'(0));
    endtask

    initial begin
        vec_t tail;
        logic [31:0] exp_d;

        vecs[0] = '{32'h0200_0000, 4'h3, 8'd0, K_CLINT, 32'h0,         2'b00};
        vecs[1] = '{32'h0200_0004, 4'h5, 8'd0, K_CLINT, 32'h0,         2'b00};
        vecs[2] = '{32'h0200_0008, 4'h7, 8'd1, K_ERR,   32'h0,         2'b00};
        vecs[3] = '{32'h8000_0000, 4'h2, 8'd0, K_SOC,   32'hDEAD_BEEF, 2'b00};
        vecs[4] = '{32'h0201_0000, 4'h9, 8'd0, K_SOC,   32'h1234_5678, 2'b01};
        vecs[5] = '{32'h0200_FFFC, 4'h1, 8'd0, K_CLINT, 32'h0,         2'b00};
        vecs[6] = '{32'h01FF_FFFC, 4'hE, 8'd0, K_SOC,   32'hCAFE_F00D, 2'b10};

        idle_inputs();

        // Reset held for three cycles
        repeat (3) @(negedge clock);
        chk("rst_arready", 64'(up_if.arready), 64'(0));
        chk("rst_rvalid", 64'(up_if.rvalid), 64'(0));
        chk("rst_rfields", 64'({up_if.rlast, up_if.rdata, up_if.rresp, up_if.rid}), 64'(0));
        chk("rst_soc", 64'({soc_if.arvalid, soc_if.rready}), 64'(0));
        chk("rst_clint", 64'({clint_if.arvalid, clint_if.rready}), 64'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("idle_arready", 64'(up_if.arready), 64'(0));

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Back-to-back CLINT low word then high word, arvalid held throughout
        @(posedge clock); #1;
        up_if.araddr = 32'h0200_0000; up_if.arid = 4'h3; up_if.arvalid = 1'b1;
        @(negedge clock);
        chk("b2b_ar0_ready", 64'(up_if.arready), 64'(1));
        @(posedge clock); #1;
        up_if.araddr = 32'h0200_0004; up_if.arid = 4'h4;
        @(negedge clock);
        chk("b2b_r0_valid", 64'(up_if.rvalid), 64'(1));
        chk("b2b_r0_data", 64'(up_if.rdata), 64'(clint_word(32'h0200_0000)));
        chk("b2b_r0_id", 64'(up_if.rid), 64'(4'h3));
        chk("b2b_r0_arready", 64'(up_if.arready), 64'(0));
        @(posedge clock); #1;
        @(negedge clock);
        chk("b2b_ar1_ready", 64'(up_if.arready), 64'(1));
        chk("b2b_gap_rvalid", 64'(up_if.rvalid), 64'(0));
        @(posedge clock); #1;
        up_if.arvalid = 1'b0;
        @(negedge clock);
        chk("b2b_r1_data", 64'(up_if.rdata), 64'(clint_word(32'h0200_0004)));
        chk("b2b_r1_id", 64'({up_if.rvalid, up_if.rlast, up_if.rresp, up_if.rid}), 64'({1'b1, 1'b1, 2'b00, 4'h4}));

        // CLINT beat stalled by rready low for four cycles
        @(posedge clock); #1;
        up_if.rready = 1'b0;
        up_if.araddr = 32'h0200_0000; up_if.arid = 4'h6; up_if.arvalid = 1'b1;
        @(negedge clock);
        chk("stall_arready", 64'(up_if.arready), 64'(1));
        @(posedge clock); #1;
        up_if.araddr = 32'h0200_0004; up_if.arid = 4'h7;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("stall%0d_rvalid", i), 64'(up_if.rvalid), 64'(1));
            chk($sformatf("stall%0d_rid", i), 64'(up_if.rid), 64'(4'h6));
            chk($sformatf("stall%0d_rdata", i), 64'(up_if.rdata), 64'(clint_word(32'h0200_0000)));
            chk($sformatf("stall%0d_arready", i), 64'(up_if.arready), 64'(0));
            @(posedge clock); #1;
        end
        up_if.rready = 1'b1;
        @(negedge clock);
        chk("stall_release_rvalid", 64'(up_if.rvalid), 64'(1));
        chk("stall_release_arready", 64'(up_if.arready), 64'(0));
        @(posedge clock); #1;
        @(negedge clock);
        chk("stall_idle_arready", 64'(up_if.arready), 64'(1));
        chk("stall_idle_rvalid", 64'(up_if.rvalid), 64'(0));
        @(posedge clock); #1;
        up_if.arvalid = 1'b0;
        @(negedge clock);
        chk("stall_next_rid", 64'(up_if.rid), 64'(4'h7));
        chk("stall_next_rdata", 64'(up_if.rdata), 64'(clint_word(32'h0200_0004)));

        // SoC burst of four beats with arready held off two cycles and one R gap
        @(posedge clock); #1;
        up_if.araddr = 32'h8000_0000; up_if.arid = 4'h9; up_if.arlen = 8'd3; up_if.arvalid = 1'b1;
        soc_if.arready = 1'b0;
        @(negedge clock);
        chk("soc_idle_arready", 64'(up_if.arready), 64'(0));
        chk("soc_idle_arvalid", 64'(soc_if.arvalid), 64'(1));
        @(posedge clock); #1;
        up_if.arvalid = 1'b0; up_if.araddr = 32'h0200_0000; up_if.arlen = 8'd0;
        @(negedge clock);
        chk("soc_ar_arready", 64'(up_if.arready), 64'(0));
        chk("soc_ar_fields", 64'({soc_if.arvalid, soc_if.araddr, soc_if.arlen, soc_if.arid}),
            64'({1'b1, 32'h8000_0000, 8'd3, 4'h9}));
        @(posedge clock); #1;
        soc_if.arready = 1'b1;
        @(negedge clock);
        chk("soc_ar2_arvalid", 64'(soc_if.arvalid), 64'(1));
        chk("soc_ar2_clint", 64'(clint_if.arvalid), 64'(0));
        @(posedge clock); #1;
        soc_if.arready = 1'b0;
        begin
            int beat = 0;
            for (int c = 0; c < 5; c++) begin
                if (c == 2) begin
                    soc_if.rvalid = 1'b0;
                    soc_if.rlast  = 1'b0;
                end else begin
                    soc_if.rvalid = 1'b1;
                    soc_if.rdata  = 32'hA000_0000 + 32'(beat);
                    soc_if.rlast  = (beat == 3);
                    soc_if.rid    = 4'h9;
                    soc_if.rresp  = 2'b00;
                end
                @(negedge clock);
                if (c == 2) begin
                    chk("soc_gap_rvalid", 64'(up_if.rvalid), 64'(0));
                end else begin
                    exp_d = 32'hA000_0000 + 32'(beat);
                    chk($sformatf("soc_b%0d_rvalid", beat), 64'(up_if.rvalid), 64'(1));
                    chk($sformatf("soc_b%0d_rdata", beat), 64'(up_if.rdata), 64'(exp_d));
                    chk($sformatf("soc_b%0d_rlast", beat), 64'(up_if.rlast), 64'(beat == 3));
                    chk($sformatf("soc_b%0d_rid", beat), 64'(up_if.rid), 64'(4'h9));
                    beat++;
                end
                @(posedge clock); #1;
            end
        end
        soc_if.rvalid = 1'b0;
        soc_if.rlast  = 1'b0;
        @(negedge clock);
        chk("soc_done_rvalid", 64'(up_if.rvalid), 64'(0));
        chk("soc_done_rready", 64'(soc_if.rready), 64'(0));

        // Reset dropped into the middle of a SoC burst
        @(posedge clock); #1;
        up_if.araddr = 32'h8000_0100; up_if.arid = 4'h2; up_if.arlen = 8'd7; up_if.arvalid = 1'b1;
        soc_if.arready = 1'b1;
        @(negedge clock);
        chk("mrst_arready", 64'(up_if.arready), 64'(1));
        @(posedge clock); #1;
        up_if.arvalid = 1'b0; up_if.arlen = 8'd0; soc_if.arready = 1'b0;
        soc_if.rvalid = 1'b1; soc_if.rdata = 32'h1111_2222; soc_if.rlast = 1'b0; soc_if.rid = 4'h2;
        @(negedge clock);
        chk("mrst_beat_rdata", 64'(up_if.rdata), 64'(32'h1111_2222));
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("mrst_in_reset_rvalid", 64'(up_if.rvalid), 64'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("mrst_after_rvalid", 64'(up_if.rvalid), 64'(0));
        chk("mrst_after_rready", 64'(soc_if.rready), 64'(0));
        @(posedge clock); #1;
        soc_if.rvalid = 1'b0;
        tail = '{32'h0200_0004, 4'hB, 8'd0, K_CLINT, 32'h0, 2'b00};
        run_vec(tail, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
